// File: rtl/minesweeper_pkg.sv
// Shared definitions for the Minesweeper design.
// Contents:
//   ms_state_e  - 3-bit game controller state encoding
//   DEF_*       - default board geometry and mine count
//   ms_width()  - bits needed to hold the values 0..n (min 1)
package minesweeper_pkg;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_INIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_WIN   = 3'd4,
    ST_LOSE  = 3'd5,
    ST_ERROR = 3'd6
  } ms_state_e;

  localparam int DEF_ROWS  = 8;
  localparam int DEF_COLS  = 8;
  localparam int DEF_MINES = 10;

  function automatic int ms_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ms_sec_timer.sv
// Elapsed-seconds timer: a prescaler counting clk cycles while run is high,
// and a seconds counter that saturates at TIME_LIMIT.
// Ports:
//   clk, rst (async, active-low)
//   run     - count this cycle
//   clear   - zero prescaler and seconds (takes priority over run)
//   seconds - elapsed seconds, saturating
//   expire  - only when MS_TIME_LIMIT_EN is defined: seconds is at, or
//             reaches on this cycle's tick, TIME_LIMIT while running
module ms_sec_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TIME_LIMIT    = 999,
  parameter int TW            = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          clear,
  output logic [TW-1:0] seconds
`ifdef MS_TIME_LIMIT_EN
  ,
  output logic          expire
`endif
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [TW-1:0] SEC_MAX   = TW'(TIME_LIMIT);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = run && (presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc   <= '0;
      seconds <= '0;
    end else if (clear) begin
      presc   <= '0;
      seconds <= '0;
    end else if (run) begin
      if (tick) begin
        presc <= '0;
        if (seconds != SEC_MAX)
          seconds <= seconds + TW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

`ifdef MS_TIME_LIMIT_EN
  // Already at the limit covers the case where a handshake kept the game in
  // PLAY on the cycle the limit was reached.
  assign expire = run && ((seconds == SEC_MAX) ||
                          (tick && (seconds == SEC_MAX - TW'(1))));
`endif

endmodule

// File: rtl/minesweeper_game_ctrl.sv
// Top-level Minesweeper game controller: board init handshake, play,
// win/lose detection, replay, and the elapsed-seconds timer.
// Optional feature macro: MS_TIME_LIMIT_EN (forced loss at TIME_LIMIT seconds).
// Ports:
//   clk, rst (async, active-low)
//   go, play_again           - level controls from the input logic
//   init_start / init_done   - board regeneration handshake
//   rev_valid/rev_ready, rev_mine, rev_count - reveal events
//   state, revealed, seconds - status
//   win, lose, done          - decoded from the registered state
module minesweeper_game_ctrl
  import minesweeper_pkg::*;
#(
  parameter int ROWS          = DEF_ROWS,
  parameter int COLS          = DEF_COLS,
  parameter int MINES         = DEF_MINES,
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TIME_LIMIT    = 999,
  localparam int CELLS        = ROWS * COLS,
  localparam int SAFE         = CELLS - MINES,
  localparam int CW           = ms_width(CELLS),
  localparam int TW           = ms_width(TIME_LIMIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic          play_again,
  output logic          init_start,
  input  logic          init_done,
  input  logic          rev_valid,
  output logic          rev_ready,
  input  logic          rev_mine,
  input  logic [CW-1:0] rev_count,
  output logic [2:0]    state,
  output logic [CW-1:0] revealed,
  output logic [TW-1:0] seconds,
  output logic          win,
  output logic          lose,
  output logic          done
);

  localparam logic [CW:0] SAFE_W = (CW + 1)'(SAFE);

  ms_state_e   state_q, state_d;
  logic        accept;
  logic [CW:0] sum;
`ifdef MS_TIME_LIMIT_EN
  logic        timeout;
`endif

  assign accept = rev_valid && rev_ready;
  // One extra bit so an inconsistent upstream count cannot wrap past SAFE.
  assign sum    = {1'b0, revealed} + {1'b0, rev_count};
  assign state  = state_q;

  ms_sec_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .TIME_LIMIT   (TIME_LIMIT),
    .TW           (TW)
  ) u_sec_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (state_q == ST_PLAY),
    .clear  (state_q == ST_START),
    .seconds(seconds)
`ifdef MS_TIME_LIMIT_EN
    ,
    .expire (timeout)
`endif
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= ST_START;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START: state_d = ST_INIT;
      ST_INIT:  if (init_done) state_d = ST_IDLE;
      ST_IDLE:  if (go) state_d = ST_PLAY;
      ST_PLAY: begin
        if (accept) begin
          if (rev_mine)
            state_d = ST_LOSE;
          else if (sum == SAFE_W)
            state_d = ST_WIN;
          else if (sum > SAFE_W)
            state_d = ST_ERROR;
        end
`ifdef MS_TIME_LIMIT_EN
        else if (timeout) begin
          state_d = ST_LOSE;
        end
`endif
      end
      ST_WIN, ST_LOSE, ST_ERROR: if (play_again) state_d = ST_START;
      default:  state_d = ST_ERROR;
    endcase
  end

  always_comb begin
    rev_ready = 1'b0;
    win       = 1'b0;
    lose      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_PLAY: rev_ready = 1'b1;
      ST_WIN: begin
        win  = 1'b1;
        done = 1'b1;
      end
      ST_LOSE: begin
        lose = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // init_start fires on the START->INIT edge, so it is high for the first
  // INIT cycle; START is always exactly one cycle long.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_start <= 1'b0;
      revealed   <= '0;
    end else begin
      init_start <= (state_q == ST_START);
      if (state_q == ST_START)
        revealed <= '0;
      else if (accept && !rev_mine && (sum <= SAFE_W))
        revealed <= sum[CW-1:0];
    end
  end

endmodule
